// File: rtl/nn_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_param_sequencer
// Purpose  : Loads the 4-neuron network's parameter shift register one byte
//            per external strobe, then sequences inference requests
//            (input capture, fixed compute latency, result-valid pulse).
// Ports    : clk, reset       - clock / synchronous active-high reset
//            start            - begin or restart a parameter load
//            byte_strobe      - asynchronous byte strobe from the pins
//            data_in[7:0]     - parameter byte from the pins
//            run              - request one inference
//            selector[1:0]    - parameter register control (01 shift, 00 hold)
//            data_out[7:0]    - registered byte for the parameter register
//            load_count[4:0]  - bytes shifted since the last start
//            loaded           - full parameter set present
//            busy             - loading or inferring
//            x_capture        - one-cycle pulse latching network inputs
//            result_valid     - one-cycle pulse, network output valid
//            error            - sticky protocol-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module nn_param_sequencer #(
    parameter int N_PARAMS       = 20,
    parameter int COMPUTE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       byte_strobe,
    input  logic [7:0] data_in,
    input  logic       run,
    output logic [1:0] selector,
    output logic [7:0] data_out,
    output logic [4:0] load_count,
    output logic       loaded,
    output logic       busy,
    output logic       x_capture,
    output logic       result_valid,
    output logic       error
);

    localparam logic [4:0] c_N_PARAMS = N_PARAMS[4:0];
    localparam int         c_CW       = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CC_LOAD = c_CW'(COMPUTE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_WAIT  = 3'd1,
        S_LOAD_SHIFT = 3'd2,
        S_READY      = 3'd3,
        S_CAPTURE    = 3'd4,
        S_COMPUTE    = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic            w_edge;

    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic [4:0]      r_count;
    logic [4:0]      w_count_nxt;
    logic [4:0]      w_count_inc;
    logic            r_loaded;
    logic            w_loaded_nxt;
    logic            r_error;
    logic            w_error_nxt;
    logic            w_clear;
    logic            w_violation;
    logic [c_CW-1:0] r_cc;
    logic [c_CW-1:0] w_cc_nxt;

    // Strobe synchronizer plus a delay flop for rising-edge detection.
    assign w_edge = r_s2 & ~r_s3;

    // Saturating increment: the count never passes the full-set size.
    assign w_count_inc = (r_count < c_N_PARAMS) ? (r_count + 5'd1) : r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_data   <= 8'd0;
            r_count  <= 5'd0;
            r_loaded <= 1'b0;
            r_error  <= 1'b0;
            r_cc     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1     <= byte_strobe;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_data   <= w_data_nxt;
            r_count  <= w_count_nxt;
            r_loaded <= w_loaded_nxt;
            r_error  <= w_error_nxt;
            r_cc     <= w_cc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_count_nxt  = r_count;
        w_loaded_nxt = r_loaded;
        w_cc_nxt     = r_cc;
        w_clear      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_WAIT;
                    w_clear     = 1'b1;
                end
            end
            S_LOAD_WAIT: begin
                if (start) begin
                    w_clear = 1'b1;
                end else if (w_edge) begin
                    w_state_nxt = S_LOAD_SHIFT;
                    w_data_nxt  = data_in;
                end
            end
            S_LOAD_SHIFT: begin
                // A restart abandons this shift; the register still shifts this
                // cycle but the count is discarded.
                if (start) begin
                    w_state_nxt = S_LOAD_WAIT;
                    w_clear     = 1'b1;
                end else begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_N_PARAMS) begin
                        w_state_nxt  = S_READY;
                        w_loaded_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD_WAIT;
                    end
                end
            end
            S_READY: begin
                if (start) begin
                    w_state_nxt = S_LOAD_WAIT;
                    w_clear     = 1'b1;
                end else if (run) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_COMPUTE;
                w_cc_nxt    = c_CC_LOAD;
            end
            S_COMPUTE: begin
                if (r_cc == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cc_nxt = r_cc - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_READY;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_clear) begin
            w_count_nxt  = 5'd0;
            w_loaded_nxt = 1'b0;
        end

        w_violation = (w_edge && (r_state != S_LOAD_WAIT)) ||
                      (run    && (r_state != S_READY));

        // A violation seen in the same cycle as an accepted start still flags.
        w_error_nxt = w_clear ? 1'b0 : r_error;
        if (w_violation) begin
            w_error_nxt = 1'b1;
        end
    end

    assign selector     = {1'b0, (r_state == S_LOAD_SHIFT)};
    assign data_out     = r_data;
    assign load_count   = r_count;
    assign loaded       = r_loaded;
    assign busy         = (r_state == S_LOAD_WAIT)  || (r_state == S_LOAD_SHIFT) ||
                          (r_state == S_CAPTURE)    || (r_state == S_COMPUTE)    ||
                          (r_state == S_DONE);
    assign x_capture    = (r_state == S_CAPTURE);
    assign result_valid = (r_state == S_DONE);
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nn_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_param_sequencer
// Purpose  : Directed self-checking bench for nn_param_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nn_param_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       byte_strobe;
    logic [7:0] data_in;
    logic       run;
    logic [1:0] selector;
    logic [7:0] data_out;
    logic [4:0] load_count;
    logic       loaded;
    logic       busy;
    logic       x_capture;
    logic       result_valid;
    logic       error;

    int         n_vec;
    int         n_bad;
    int         n_shift;
    logic [7:0] shift_q[$];

    nn_param_sequencer #(
        .N_PARAMS       (20),
        .COMPUTE_CYCLES (2)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_strobe  (byte_strobe),
        .data_in      (data_in),
        .run          (run),
        .selector     (selector),
        .data_out     (data_out),
        .load_count   (load_count),
        .loaded       (loaded),
        .busy         (busy),
        .x_capture    (x_capture),
        .result_valid (result_valid),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every shift pulse and the byte presented with it.
    always @(negedge clk) begin
        if (selector == 2'b01) begin
            n_shift++;
            shift_q.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Strobe high for 2 samples, low for 3; returns after the shift completes.
    task automatic send_byte(input logic [7:0] b);
        data_in     = b;
        byte_strobe = 1'b1;
        step(2);
        byte_strobe = 1'b0;
        step(3);
    endtask

    function automatic logic [20:0] all_outs();
        return {selector, data_out, load_count, loaded, busy, x_capture, result_valid, error};
    endfunction

    initial begin
        logic [7:0] exp_b;
        n_vec       = 0;
        n_bad       = 0;
        n_shift     = 0;
        reset       = 1'b1;
        start       = 1'b0;
        byte_strobe = 1'b0;
        data_in     = 8'h00;
        run         = 1'b0;
        step(2);
        check("reset_outs", {11'd0, all_outs()}, 32'd0);
        reset = 1'b0;
        step(1);

        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);

        // Cycle-exact timing of the first byte (strobe first sampled at edge n).
        data_in     = 8'h01;
        byte_strobe = 1'b1;
        step(1);                                   // after edge n
        check("sel_n", {30'd0, selector}, 32'd0);
        step(1);                                   // after edge n+1
        check("sel_n1", {30'd0, selector}, 32'd0);
        byte_strobe = 1'b0;
        step(1);                                   // after edge n+2
        check("sel_n2", {30'd0, selector}, 32'd1);
        check("dout_n2", {24'd0, data_out}, 32'h01);
        check("cnt_n2", {27'd0, load_count}, 32'd0);
        step(1);                                   // after edge n+3
        check("sel_n3", {30'd0, selector}, 32'd0);
        check("cnt_n3", {27'd0, load_count}, 32'd1);
        step(1);

        for (int i = 2; i <= 7; i++) send_byte(8'(i));
        check("cnt7", {27'd0, load_count}, 32'd7);

        pulse_start();
        check("restart_cnt", {27'd0, load_count}, 32'd0);
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        check("full_cnt", {27'd0, load_count}, 32'd20);
        check("full_loaded", {31'd0, loaded}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd0);
        check("full_err", {31'd0, error}, 32'd0);
        check("shift27", n_shift, 32'd27);
        check("q_size", shift_q.size(), 32'd27);
        for (int i = 0; i < 27; i++) begin
            exp_b = (i < 7) ? 8'(i + 1) : 8'(i - 6);
            if (i < shift_q.size()) check($sformatf("q%0d", i), {24'd0, shift_q[i]}, {24'd0, exp_b});
        end

        // Inference: run sampled at edge m.
        run = 1'b1;
        step(1);                                   // after m
        run = 1'b0;
        check("xcap_m", {31'd0, x_capture}, 32'd1);
        check("busy_m", {31'd0, busy}, 32'd1);
        step(1);                                   // after m+1
        check("xcap_m1", {30'd0, x_capture, result_valid}, 32'd0);
        step(1);                                   // after m+2
        check("rv_m2", {31'd0, result_valid}, 32'd0);
        step(1);                                   // after m+3
        check("rv_m3", {30'd0, result_valid, busy}, 32'd3);
        step(1);                                   // after m+4
        check("rv_m4", {30'd0, result_valid, busy}, 32'd0);
        check("inf_err", {31'd0, error}, 32'd0);

        // Strobe while READY.
        send_byte(8'hAA);
        check("ready_strobe_err", {31'd0, error}, 32'd1);
        check("ready_strobe_cnt", {27'd0, load_count}, 32'd20);
        check("ready_strobe_shift", n_shift, 32'd27);
        pulse_start();
        check("start_clr_err", {26'd0, error, loaded, load_count}, 32'd0);

        // Run while LOAD_WAIT.
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("wait_run_err", {30'd0, error, busy}, 32'd3);
        pulse_start();
        check("start_clr_err2", {31'd0, error}, 32'd0);

        // Reset mid-load with an edge pending.
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
        check("cnt3", {27'd0, load_count}, 32'd3);
        data_in     = 8'h55;
        byte_strobe = 1'b1;
        step(2);
        reset       = 1'b1;
        byte_strobe = 1'b0;
        step(1);
        check("rst_load_outs", {11'd0, all_outs()}, 32'd0);
        reset = 1'b0;
        step(3);
        check("rst_load_shift", n_shift, 32'd30);
        send_byte(8'h66);
        check("idle_strobe_err", {31'd0, error}, 32'd1);
        check("idle_strobe", {26'd0, busy, load_count}, 32'd0);
        check("idle_strobe_shift", n_shift, 32'd30);

        // Reload, then reset mid-COMPUTE.
        pulse_start();
        for (int i = 0; i < 20; i++) send_byte(8'h21 + 8'(i));
        check("reload", {26'd0, loaded, load_count}, 32'h34);
        check("shift50", n_shift, 32'd50);
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("xcap2", {31'd0, x_capture}, 32'd1);
        step(1);
        reset = 1'b1;
        step(1);
        check("rst_comp_outs", {11'd0, all_outs()}, 32'd0);
        reset = 1'b0;
        step(1);
        check("rst_comp_idle", {11'd0, all_outs()}, 32'd0);
        send_byte(8'h77);
        check("post_rst_strobe", {30'd0, error, busy}, 32'd2);
        check("post_rst_shift", n_shift, 32'd50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
